// File: rtl/uart_cmd_bridge_pkg.sv
// Shared opcodes, FSM states and error codes for the UART command bridge.
package uart_cmd_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_HALT  = 8'h02;
    localparam logic [7:0] OP_RESET = 8'h03;
    localparam logic [7:0] OP_START = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_COUNT = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4
    } bridge_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_OPCODE  = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } bridge_err_t;

endpackage

// File: rtl/uart_cmd_bridge.sv
// Parses framed UART bytes into burst RAM writes and one-cycle CPU control pulses,
// with checksum verification and an inter-byte timeout.
module uart_cmd_bridge
    import uart_cmd_bridge_pkg::*;
#(
    parameter int unsigned ADDR_BYTES     = 4,
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [7:0]              data_in,
    input  logic                    valid_in,
    output logic [8*ADDR_BYTES-1:0] addr_out,
    output logic [8*DATA_BYTES-1:0] data_out,
    output logic                    valid_out,
    output logic                    halt_out,
    output logic                    reset_out,
    output logic                    start_out,
    output logic                    pkt_ok_out,
    output logic                    error_out,
    output logic [1:0]              error_code_out
);

    localparam int unsigned ADDR_W   = 8 * ADDR_BYTES;
    localparam int unsigned DATA_W   = 8 * DATA_BYTES;
    localparam int unsigned MAX_B    = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int unsigned IDX_W    = (MAX_B > 1) ? $clog2(MAX_B) : 1;
    localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BYTES - 1);

    bridge_state_t     state_q, state_d;
    bridge_err_t       err_code_q, err_code_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [8:0]        words_q, words_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0] word_sh_q, word_sh_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              halt_q, halt_d;
    logic              reset_q, reset_d;
    logic              start_q, start_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              timeout_fire;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] word_next;

    // Little-endian shift-in: each new byte enters at the top and slides down.
    assign addr_next = (addr_sh_q >> 8) | (ADDR_W'(data_in) << (ADDR_W - 8));
    assign word_next = (word_sh_q >> 8) | (DATA_W'(data_in) << (DATA_W - 8));

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        idx_d      = idx_q;
        words_d    = words_q;
        addr_sh_d  = addr_sh_q;
        word_sh_d  = word_sh_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        halt_d     = 1'b0;
        reset_d    = 1'b0;
        start_d    = 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        tmo_d      = (state_q == ST_IDLE || valid_in) ? '0 : tmo_q + TMO_W'(1);

        timeout_fire = (TIMEOUT_CYCLES != 0) && (state_q != ST_IDLE)
                       && (tmo_q == TMO_W'(TMO_LAST));

        // Timeout takes priority over a byte arriving in the same cycle.
        if (timeout_fire) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_IDLE;
            tmo_d      = '0;
        end else if (valid_in) begin
            case (state_q)
                ST_IDLE: begin
                    csum_d = data_in;
                    idx_d  = '0;
                    case (data_in)
                        OP_WRITE: state_d = ST_ADDR;
                        OP_HALT:  begin halt_d  = 1'b1; ok_d = 1'b1; end
                        OP_RESET: begin reset_d = 1'b1; ok_d = 1'b1; end
                        OP_START: begin start_d = 1'b1; ok_d = 1'b1; end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_OPCODE;
                        end
                    endcase
                end
                ST_ADDR: begin
                    csum_d    = csum_q + data_in;
                    addr_sh_d = addr_next;
                    if (idx_q == ADDR_LAST) begin
                        idx_d   = '0;
                        state_d = ST_COUNT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_COUNT: begin
                    csum_d  = csum_q + data_in;
                    words_d = (data_in == 8'h00) ? 9'd256 : {1'b0, data_in};
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    csum_d    = csum_q + data_in;
                    word_sh_d = word_next;
                    if (idx_q == DATA_LAST) begin
                        idx_d     = '0;
                        valid_d   = 1'b1;
                        addr_d    = addr_sh_q;
                        data_d    = word_next;
                        addr_sh_d = addr_sh_q + ADDR_W'(DATA_BYTES);
                        words_d   = words_q - 9'd1;
                        if (words_q == 9'd1) state_d = ST_CSUM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (csum_q == data_in) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            idx_q      <= '0;
            words_q    <= '0;
            addr_sh_q  <= '0;
            word_sh_q  <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            halt_q     <= 1'b0;
            reset_q    <= 1'b0;
            start_q    <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            idx_q      <= idx_d;
            words_q    <= words_d;
            addr_sh_q  <= addr_sh_d;
            word_sh_q  <= word_sh_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            halt_q     <= halt_d;
            reset_q    <= reset_d;
            start_q    <= start_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign addr_out       = addr_q;
    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign halt_out       = halt_q;
    assign reset_out      = reset_q;
    assign start_out      = start_q;
    assign pkt_ok_out     = ok_q;
    assign error_out      = err_q;
    assign error_code_out = err_code_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed self-checking bench for uart_cmd_bridge (32-bit address/data, 100-cycle timeout).
module tb_uart_cmd_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic        valid_out, halt_out, reset_out, start_out, pkt_ok_out, error_out;
    logic [1:0]  error_code_out;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Pulse bit order: valid, halt, reset, start, pkt_ok, error
    localparam logic [5:0] P_NONE  = 6'b000000;
    localparam logic [5:0] P_VALID = 6'b100000;
    localparam logic [5:0] P_HALT  = 6'b010010;
    localparam logic [5:0] P_START = 6'b000110;
    localparam logic [5:0] P_OK    = 6'b000010;
    localparam logic [5:0] P_ERR   = 6'b000001;

    uart_cmd_bridge #(
        .ADDR_BYTES(4),
        .DATA_BYTES(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .data_in(data_in),
        .valid_in(valid_in),
        .addr_out(addr_out),
        .data_out(data_out),
        .valid_out(valid_out),
        .halt_out(halt_out),
        .reset_out(reset_out),
        .start_out(start_out),
        .pkt_ok_out(pkt_ok_out),
        .error_out(error_out),
        .error_code_out(error_code_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [5:0] pulses();
        return {valid_out, halt_out, reset_out, start_out, pkt_ok_out, error_out};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one clock; returns #1 after the sampling edge so
    // its registered response is visible. Consecutive calls are back-to-back.
    task automatic drive(input logic [7:0] b);
        data_in  = b;
        valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Two-word WRITE frame; checks each emitted word as it completes.
    task automatic wr2(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] exp_a0, input logic [31:0] exp_a1, input logic [7:0] cs);
        drive(8'h01);
        for (int i = 0; i < 4; i++) drive(base[8*i +: 8]);
        drive(8'h02);
        for (int i = 0; i < 3; i++) drive(w0[8*i +: 8]);
        chk("w0_not_yet", 32'(pulses()), 32'(P_NONE));
        drive(w0[31:24]);
        chk("w0_pulse", 32'(pulses()), 32'(P_VALID));
        chk("w0_addr", addr_out, exp_a0);
        chk("w0_data", data_out, w0);
        drive(w1[7:0]);
        chk("w0_one_cycle", 32'(pulses()), 32'(P_NONE));
        chk("w0_addr_hold", addr_out, exp_a0);
        for (int i = 1; i < 4; i++) drive(w1[8*i +: 8]);
        chk("w1_pulse", 32'(pulses()), 32'(P_VALID));
        chk("w1_addr", addr_out, exp_a1);
        chk("w1_data", data_out, w1);
        drive(cs);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        idle(2);
        rst_in = 1'b0;
        chk("rst_pulses", 32'(pulses()), 32'(P_NONE));
        chk("rst_addr", addr_out, 32'h0);
        chk("rst_data", data_out, 32'h0);
        chk("rst_code", 32'(error_code_out), 32'd0);

        // HALT
        drive(8'h02);
        chk("halt_pulse", 32'(pulses()), 32'(P_HALT));
        idle(1);
        chk("halt_one_cycle", 32'(pulses()), 32'(P_NONE));

        // Good WRITE: byte sum 0x45F -> checksum 0x5F
        wr2(32'h0000_1000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_1000, 32'h0000_1004, 8'h5F);
        chk("wr_ok", 32'(pulses()), 32'(P_OK));
        chk("wr_ok_code", 32'(error_code_out), 32'd0);

        // Same frame back-to-back with a wrong checksum
        wr2(32'h0000_1000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_1000, 32'h0000_1004, 8'h00);
        chk("csum_err", 32'(pulses()), 32'(P_ERR));
        chk("csum_code", 32'(error_code_out), 32'd2);
        idle(1);
        chk("csum_err_one_cycle", 32'(pulses()), 32'(P_NONE));
        chk("csum_code_hold", 32'(error_code_out), 32'd2);

        // Bad opcode then START
        drive(8'h7F);
        chk("badop_err", 32'(pulses()), 32'(P_ERR));
        chk("badop_code", 32'(error_code_out), 32'd1);
        drive(8'h04);
        chk("start_after_badop", 32'(pulses()), 32'(P_START));
        chk("badop_code_hold", 32'(error_code_out), 32'd1);

        // Timeout: opcode + 3 address bytes, then stall
        drive(8'h01);
        drive(8'h00);
        drive(8'h00);
        drive(8'h00);
        idle(99);
        chk("tmo_not_early", 32'(pulses()), 32'(P_NONE));
        idle(1);
        chk("tmo_err", 32'(pulses()), 32'(P_ERR));
        chk("tmo_code", 32'(error_code_out), 32'd3);
        idle(1);
        chk("tmo_one_cycle", 32'(pulses()), 32'(P_NONE));
        drive(8'h04);
        chk("start_after_tmo", 32'(pulses()), 32'(P_START));

        // Address wrap: 01 FC FF FF FF 02 + 8 data bytes, sum 0x660 -> 0x60
        wr2(32'hFFFF_FFFC, 32'h4433_2211, 32'h8877_6655, 32'hFFFF_FFFC, 32'h0000_0000, 8'h60);
        chk("wrap_ok", 32'(pulses()), 32'(P_OK));

        // Reset mid-DATA
        drive(8'h01);
        drive(8'h00);
        drive(8'h20);
        drive(8'h00);
        drive(8'h00);
        drive(8'h01);
        drive(8'hAA);
        drive(8'hBB);
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        chk("midrst_pulses", 32'(pulses()), 32'(P_NONE));
        chk("midrst_addr", addr_out, 32'h0);
        chk("midrst_data", data_out, 32'h0);
        chk("midrst_code", 32'(error_code_out), 32'd0);
        idle(3);
        chk("midrst_no_write", 32'(pulses()), 32'(P_NONE));
        drive(8'h02);
        chk("midrst_next_opcode", 32'(pulses()), 32'(P_HALT));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
